// File: rtl/fa_1bit_reg.sv
// Registered 1-bit full adder cell with a valid flag carried alongside the result.
// Optional FA1BIT_SERIAL_EN adds fa_port_first and an internal carry register for bit-serial adds.
module fa_1bit_reg #(
  parameter int OUT_REG = 1
) (
  input  logic       fa_port_clk,
  input  logic       fa_port_rst,
  input  logic [2:0] fa_port_input,
  input  logic       fa_port_valid_in,
`ifdef FA1BIT_SERIAL_EN
  input  logic       fa_port_first,
`endif
  output logic [1:0] fa_port_output,
  output logic       fa_port_valid_out
);

  logic       a, b, cin, sum, cout;
  logic [1:0] res_d;

  // Serial mode: carry_q stands in for cin except on the LSB of a word.
`ifdef FA1BIT_SERIAL_EN
  logic carry_q, carry_d;
`endif

  always_comb begin
    a   = fa_port_input[0];
    b   = fa_port_input[1];
`ifdef FA1BIT_SERIAL_EN
    cin = fa_port_first ? fa_port_input[2] : carry_q;
`else
    cin = fa_port_input[2];
`endif
    sum   = a ^ b ^ cin;
    cout  = (a & b) | (a & cin) | (b & cin);
    res_d = {cout, sum};
  end

`ifdef FA1BIT_SERIAL_EN
  always_comb begin
    carry_d = carry_q;
    if (fa_port_valid_in) carry_d = cout;
  end

  always_ff @(posedge fa_port_clk) begin
    if (fa_port_rst) carry_q <= 1'b0;
    else             carry_q <= carry_d;
  end
`endif

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [1:0] out_q;
      logic       vld_q;

      // Loads every cycle; valid only qualifies, never gates the load.
      always_ff @(posedge fa_port_clk) begin
        if (fa_port_rst) begin
          out_q <= 2'b00;
          vld_q <= 1'b0;
        end else begin
          out_q <= res_d;
          vld_q <= fa_port_valid_in;
        end
      end

      assign fa_port_output    = out_q;
      assign fa_port_valid_out = vld_q;
    end else begin : g_comb
      assign fa_port_output    = res_d;
      assign fa_port_valid_out = fa_port_valid_in;
    end
  endgenerate

endmodule

// File: tb/tb_fa_1bit_reg.sv
// Directed bench for fa_1bit_reg: registered and combinational instances side by side.
// Serial-mode steps are compiled in when FA1BIT_SERIAL_EN is defined.
module tb_fa_1bit_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] din;
  logic       vin;
  logic       first;
  logic [1:0] out_r, out_c;
  logic       vout_r, vout_c;
  int         tests = 0;
  int         fails = 0;

  always #10 clk = ~clk;

  fa_1bit_reg #(.OUT_REG(1)) u_reg (
    .fa_port_clk(clk), .fa_port_rst(rst), .fa_port_input(din),
    .fa_port_valid_in(vin),
`ifdef FA1BIT_SERIAL_EN
    .fa_port_first(first),
`endif
    .fa_port_output(out_r), .fa_port_valid_out(vout_r)
  );

  fa_1bit_reg #(.OUT_REG(0)) u_comb (
    .fa_port_clk(clk), .fa_port_rst(rst), .fa_port_input(din),
    .fa_port_valid_in(vin),
`ifdef FA1BIT_SERIAL_EN
    .fa_port_first(first),
`endif
    .fa_port_output(out_c), .fa_port_valid_out(vout_c)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] v;
    logic [1:0] e;
    rst = 1'b1; din = 3'b111; vin = 1'b1; first = 1'b1;
    tick();
    chk("reset_out", out_r, 2'b00);
    chk("reset_vld", {1'b0, vout_r}, 2'b00);
    chk("comb_ignores_rst", out_c, 2'b11);
    chk("comb_vld_ignores_rst", {1'b0, vout_c}, 2'b01);
    rst = 1'b0;

    // exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      e = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      din = v; vin = 1'b1;
      #1;
      chk($sformatf("comb_sweep_%0d", i), out_c, e);
      tick();
      chk($sformatf("reg_sweep_%0d", i), out_r, e);
      chk($sformatf("reg_sweep_vld_%0d", i), {1'b0, vout_r}, 2'b01);
    end
    din = 3'b011; tick(); chk("ex_011", out_r, 2'b10);
    din = 3'b101; tick(); chk("ex_101", out_r, 2'b10);

    // reset mid-stream, reset priority over sampling
    din = 3'b111; vin = 1'b1; tick();
    chk("pre_rst_out", out_r, 2'b11);
    rst = 1'b1; tick();
    chk("rst_out", out_r, 2'b00);
    chk("rst_vld", {1'b0, vout_r}, 2'b00);
    rst = 1'b0; tick();
    chk("post_rst_out", out_r, 2'b11);
    chk("post_rst_vld", {1'b0, vout_r}, 2'b01);

    // valid pipeline 1,0,1; output still updates when invalid
    din = 3'b001; vin = 1'b1; tick();
    chk("vp0_vld", {1'b0, vout_r}, 2'b01); chk("vp0_out", out_r, 2'b01);
    din = 3'b110; vin = 1'b0; tick();
    chk("vp1_vld", {1'b0, vout_r}, 2'b00); chk("vp1_out", out_r, 2'b10);
    din = 3'b111; vin = 1'b1; tick();
    chk("vp2_vld", {1'b0, vout_r}, 2'b01); chk("vp2_out", out_r, 2'b11);

    // combinational instance: no edge needed
    @(negedge clk);
    din = 3'b110; vin = 1'b0;
    #1;
    chk("comb_110", out_c, 2'b10);
    chk("comb_vld0", {1'b0, vout_c}, 2'b00);
    vin = 1'b1; #1;
    chk("comb_vld1", {1'b0, vout_c}, 2'b01);
    tick();

`ifdef FA1BIT_SERIAL_EN
    // 3 + 1 LSB first; din[2] forced high off the LSB to show it is ignored
    din = 3'b011; first = 1'b1; vin = 1'b1; tick();
    chk("ser_b0", out_r, 2'b10);
    din = 3'b101; first = 1'b0; tick();
    chk("ser_b1", out_r, 2'b10);
    din = 3'b100; tick();
    chk("ser_b2", out_r, 2'b01);

    // same word with a gap after bit0: carry must be held
    din = 3'b011; first = 1'b1; vin = 1'b1; tick();
    chk("gap_b0", out_r, 2'b10);
    din = 3'b000; first = 1'b0; vin = 1'b0; tick();
    chk("gap_hold_out", out_r, 2'b01);
    chk("gap_hold_vld", {1'b0, vout_r}, 2'b00);
    din = 3'b101; vin = 1'b1; tick();
    chk("gap_b1", out_r, 2'b10);
    din = 3'b100; tick();
    chk("gap_b2", out_r, 2'b01);

    // reset clears carry and wins over first
    din = 3'b011; first = 1'b1; tick();
    rst = 1'b1; first = 1'b1; din = 3'b111; tick();
    chk("ser_rst_out", out_r, 2'b00);
    rst = 1'b0; first = 1'b0; din = 3'b100; tick();
    chk("ser_carry_cleared", out_r, 2'b00);
    first = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
